// File: rtl/bpu_dir_pred_module_pkg.sv
// Shared BPU definitions: default widths, counter init value and saturating
// counter arithmetic, reused by the direction predictor and later BTB/RAS blocks.
package bpu_dir_pred_module_pkg;

   localparam int unsigned PC_W_DEF      = 32;
   localparam int unsigned PC_LSB_DEF    = 4;
   localparam int unsigned PHT_IDX_W_DEF = 8;
   localparam int unsigned GHR_W_DEF     = 8;
   localparam int unsigned CTR_W_DEF     = 2;
   localparam int unsigned CTR_W_MAX     = 4;

   typedef logic [CTR_W_MAX-1:0] ctr_max_t;

   // Weakly not-taken: one below the taken threshold.
   function automatic ctr_max_t ctr_init(input int unsigned w);
      return ctr_max_t'((1 << (w - 1)) - 1);
   endfunction

   // Saturating increment/decrement for a w-bit counter held in ctr_max_t.
   function automatic ctr_max_t ctr_sat_upd(input ctr_max_t c, input logic taken,
                                            input int unsigned w);
      ctr_max_t max_v;
      max_v = ctr_max_t'((1 << w) - 1);
      if (taken) return (c == max_v) ? c : c + 1'b1;
      return (c == '0) ? c : c - 1'b1;
   endfunction

endpackage

// File: rtl/bpu_dir_pred_module_pht.sv
// Pattern history table: flop array of saturating counters with one registered
// read port, one read-modify-write update port and update->read bypass.
module bpu_dir_pred_module_pht
   import bpu_dir_pred_module_pkg::*;
#(
   parameter int unsigned IDX_W = PHT_IDX_W_DEF,
   parameter int unsigned CTR_W = CTR_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_rd_en,
   input  logic [IDX_W-1:0] i_rd_idx,
   output logic [CTR_W-1:0] o_rd_ctr,
   input  logic             i_wr_vld,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic             i_wr_taken
);

   localparam int unsigned      DEPTH    = 1 << IDX_W;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));

   logic [DEPTH-1:0][CTR_W-1:0] r_pht;
   logic [CTR_W-1:0]            r_rd_ctr;
   logic [CTR_W-1:0]            w_wr_cur;
   logic [CTR_W-1:0]            w_wr_nxt;
   logic [CTR_W-1:0]            w_rd_ctr;

   assign w_wr_cur = r_pht[i_wr_idx];
   assign w_wr_nxt = CTR_W'(ctr_sat_upd(ctr_max_t'(w_wr_cur), i_wr_taken, CTR_W));
   // A read of the entry being updated this cycle sees the post-update value.
   assign w_rd_ctr = (i_wr_vld && (i_wr_idx == i_rd_idx)) ? w_wr_nxt : r_pht[i_rd_idx];
   assign o_rd_ctr = r_rd_ctr;

   // Counter array: reset to weakly not-taken, RMW on update.
   always_ff @(posedge clk) begin
      if (rst)           r_pht           <= {DEPTH{CTR_INIT}};
      else if (i_wr_vld) r_pht[i_wr_idx] <= w_wr_nxt;
   end

   // Registered read port; holds the last value when no read is issued.
   always_ff @(posedge clk) begin
      if (rst)          r_rd_ctr <= '0;
      else if (i_rd_en) r_rd_ctr <= w_rd_ctr;
   end

endmodule

// File: rtl/bpu_dir_pred_module.sv
// Gshare direction predictor: PC ^ speculative GHR indexes the PHT, speculative
// history is repaired from a checkpoint on mispredict and from the committed
// history on flush.
module bpu_dir_pred_module
   import bpu_dir_pred_module_pkg::*;
#(
   parameter int unsigned PC_W      = PC_W_DEF,
   parameter int unsigned PC_LSB    = PC_LSB_DEF,
   parameter int unsigned PHT_IDX_W = PHT_IDX_W_DEF,
   parameter int unsigned GHR_W     = GHR_W_DEF,
   parameter int unsigned CTR_W     = CTR_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_flush,
   input  logic                 i_pred_vld,
   input  logic [PC_W-1:0]      i_pred_pc,
   output logic                 o_pred_vld,
   output logic                 o_pred_taken,
   output logic [PHT_IDX_W-1:0] o_pred_idx,
   output logic [CTR_W-1:0]     o_pred_ctr,
   output logic [GHR_W-1:0]     o_pred_ghr,
   input  logic                 i_spec_vld,
   input  logic                 i_spec_taken,
   input  logic                 i_upd_vld,
   input  logic [PHT_IDX_W-1:0] i_upd_idx,
   input  logic                 i_upd_taken,
   input  logic                 i_upd_mispred,
   input  logic [GHR_W-1:0]     i_upd_ghr
);

   logic                 r_pred_vld;
   logic [PHT_IDX_W-1:0] r_pred_idx;
   logic [GHR_W-1:0]     r_pred_ghr;
   logic [GHR_W-1:0]     r_sghr;
   logic [GHR_W-1:0]     r_cghr;
   logic [GHR_W-1:0]     w_sghr_nxt;
   logic [GHR_W-1:0]     w_cghr_nxt;
   logic [PHT_IDX_W-1:0] w_idx;
   logic                 w_rd_en;
   logic                 w_unused_pc;

   // Shift-in written as a shift so a 1-bit history just takes the new bit.
   function automatic logic [GHR_W-1:0] f_shift(input logic [GHR_W-1:0] g, input logic b);
      return (g << 1) | GHR_W'(b);
   endfunction

   assign w_unused_pc = ^i_pred_pc;
   assign w_idx       = i_pred_pc[PC_LSB +: PHT_IDX_W] ^ PHT_IDX_W'(r_sghr);
   // A flushed request is dropped entirely, so outputs keep their old values.
   assign w_rd_en     = i_pred_vld & ~i_flush;
   assign w_cghr_nxt  = i_upd_vld ? f_shift(r_cghr, i_upd_taken) : r_cghr;

   bpu_dir_pred_module_pht #(.IDX_W(PHT_IDX_W), .CTR_W(CTR_W)) u_pht (
      .clk        (clk),
      .rst        (rst),
      .i_rd_en    (w_rd_en),
      .i_rd_idx   (w_idx),
      .o_rd_ctr   (o_pred_ctr),
      .i_wr_vld   (i_upd_vld),
      .i_wr_idx   (i_upd_idx),
      .i_wr_taken (i_upd_taken)
   );

   // Speculative history next state: flush > mispredict repair > spec shift > hold.
   always_comb begin
      w_sghr_nxt = r_sghr;
      if (i_flush)                        w_sghr_nxt = w_cghr_nxt;
      else if (i_upd_vld && i_upd_mispred) w_sghr_nxt = f_shift(i_upd_ghr, i_upd_taken);
      else if (i_spec_vld)                w_sghr_nxt = f_shift(r_sghr, i_spec_taken);
   end

   // History registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sghr <= '0;
         r_cghr <= '0;
      end else begin
         r_sghr <= w_sghr_nxt;
         r_cghr <= w_cghr_nxt;
      end
   end

   // Prediction output registers; only valid drops when there is no request.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pred_vld <= 1'b0;
         r_pred_idx <= '0;
         r_pred_ghr <= '0;
      end else begin
         r_pred_vld <= w_rd_en;
         if (w_rd_en) begin
            r_pred_idx <= w_idx;
            r_pred_ghr <= r_sghr;
         end
      end
   end

   assign o_pred_vld   = r_pred_vld;
   assign o_pred_idx   = r_pred_idx;
   assign o_pred_ghr   = r_pred_ghr;
   assign o_pred_taken = o_pred_ctr[CTR_W-1];

endmodule

// File: tb/tb_bpu_dir_pred_module.sv
// Bench for the gshare predictor: directed scenarios plus randomized traffic
// against a behavioural model (integer counters, integer histories).
module tb_bpu_dir_pred_module;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_flush = 1'b0;
   logic        i_pred_vld = 1'b0;
   logic [31:0] i_pred_pc = '0;
   logic        o_pred_vld;
   logic        o_pred_taken;
   logic [7:0]  o_pred_idx;
   logic [1:0]  o_pred_ctr;
   logic [7:0]  o_pred_ghr;
   logic        i_spec_vld = 1'b0;
   logic        i_spec_taken = 1'b0;
   logic        i_upd_vld = 1'b0;
   logic [7:0]  i_upd_idx = '0;
   logic        i_upd_taken = 1'b0;
   logic        i_upd_mispred = 1'b0;
   logic [7:0]  i_upd_ghr = '0;

   int checks = 0;
   int errors = 0;

   // reference model state
   int   m_pht[256];
   int   m_sghr, m_cghr;
   logic exp_vld;
   int   exp_ctr, exp_idx, exp_ghr;

   bpu_dir_pred_module dut (
      .clk(clk), .rst(rst), .i_flush(i_flush),
      .i_pred_vld(i_pred_vld), .i_pred_pc(i_pred_pc),
      .o_pred_vld(o_pred_vld), .o_pred_taken(o_pred_taken), .o_pred_idx(o_pred_idx),
      .o_pred_ctr(o_pred_ctr), .o_pred_ghr(o_pred_ghr),
      .i_spec_vld(i_spec_vld), .i_spec_taken(i_spec_taken),
      .i_upd_vld(i_upd_vld), .i_upd_idx(i_upd_idx), .i_upd_taken(i_upd_taken),
      .i_upd_mispred(i_upd_mispred), .i_upd_ghr(i_upd_ghr)
   );

   always #5 clk = ~clk;

   function automatic logic [19:0] exp_vec();
      return {exp_vld, logic'(exp_ctr >= 2), 8'(exp_idx), 2'(exp_ctr), 8'(exp_ghr)};
   endfunction

   function automatic logic [19:0] obs_vec();
      return {o_pred_vld, o_pred_taken, o_pred_idx, o_pred_ctr, o_pred_ghr};
   endfunction

   task automatic model_init();
      for (int i = 0; i < 256; i++) m_pht[i] = 1;
      m_sghr = 0; m_cghr = 0;
      exp_vld = 1'b0; exp_ctr = 0; exp_idx = 0; exp_ghr = 0;
   endtask

   task automatic apply_reset();
      rst = 1'b1; i_flush = 0; i_pred_vld = 0; i_spec_vld = 0; i_upd_vld = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_init();
   endtask

   // One cycle of stimulus; the model predicts the outputs seen after the edge.
   task automatic step(input logic fl, input logic pv, input logic [31:0] pc,
                       input logic sv, input logic st, input logic uv,
                       input logic [7:0] ui, input logic ut, input logic um,
                       input logic [7:0] ug);
      int hidx, cn;
      i_flush = fl; i_pred_vld = pv; i_pred_pc = pc; i_spec_vld = sv; i_spec_taken = st;
      i_upd_vld = uv; i_upd_idx = ui; i_upd_taken = ut; i_upd_mispred = um; i_upd_ghr = ug;
      hidx = int'(pc[11:4]) ^ m_sghr;
      if (uv) begin
         if (ut) m_pht[ui] = (m_pht[ui] == 3) ? 3 : m_pht[ui] + 1;
         else    m_pht[ui] = (m_pht[ui] == 0) ? 0 : m_pht[ui] - 1;
      end
      if (pv && !fl) begin
         exp_vld = 1'b1; exp_idx = hidx; exp_ghr = m_sghr; exp_ctr = m_pht[hidx];
      end else exp_vld = 1'b0;
      cn = uv ? ((m_cghr * 2) + int'(ut)) % 256 : m_cghr;
      if (fl)            m_sghr = cn;
      else if (uv && um) m_sghr = ((int'(ug) * 2) + int'(ut)) % 256;
      else if (sv)       m_sghr = ((m_sghr * 2) + int'(st)) % 256;
      m_cghr = cn;
      @(posedge clk); #1;
   endtask

   task automatic idle();             step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic query(input logic [31:0] pc); step(0, 1, pc, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic upd(input logic [7:0] ix, input logic t); step(0, 0, 0, 0, 0, 1, ix, t, 0, 0); endtask
   task automatic spec(input logic t); step(0, 0, 0, 1, t, 0, 0, 0, 0, 0); endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (obs_vec() !== 20'h0) begin
         errors++; $display("FAIL reset_outputs: got %h expected %h", obs_vec(), 20'h0);
      end
      query(32'h100);
      checks++;
      if ({o_pred_vld, o_pred_taken, o_pred_idx, o_pred_ctr, o_pred_ghr} !== {1'b1, 1'b0, 8'h10, 2'd1, 8'h00}) begin
         errors++; $display("FAIL first_query: got %h expected %h", obs_vec(), {1'b1, 1'b0, 8'h10, 2'd1, 8'h00});
      end
      idle();
      checks++;
      if ({o_pred_vld, o_pred_idx, o_pred_ctr} !== {1'b0, 8'h10, 2'd1}) begin
         errors++; $display("FAIL idle_hold: got %h expected %h", {o_pred_vld, o_pred_idx, o_pred_ctr}, {1'b0, 8'h10, 2'd1});
      end
   endtask

   task automatic test_saturation();
      upd(8'h10, 1); upd(8'h10, 1); query(32'h100);
      checks++;
      if ({o_pred_ctr, o_pred_taken} !== {2'd3, 1'b1}) begin
         errors++; $display("FAIL sat_inc: got %h expected %h", {o_pred_ctr, o_pred_taken}, {2'd3, 1'b1});
      end
      upd(8'h10, 1); query(32'h100);
      checks++;
      if (o_pred_ctr !== 2'd3) begin
         errors++; $display("FAIL sat_top: got %0d expected 3", o_pred_ctr);
      end
      for (int i = 0; i < 4; i++) upd(8'h10, 0);
      query(32'h100);
      checks++;
      if ({o_pred_ctr, o_pred_taken} !== {2'd0, 1'b0}) begin
         errors++; $display("FAIL sat_dec: got %h expected %h", {o_pred_ctr, o_pred_taken}, {2'd0, 1'b0});
      end
      upd(8'h10, 0); query(32'h100);
      checks++;
      if (o_pred_ctr !== 2'd0) begin
         errors++; $display("FAIL sat_bottom: got %0d expected 0", o_pred_ctr);
      end
   endtask

   task automatic test_spec_history();
      apply_reset();
      spec(1); spec(1); spec(1);
      query(32'h100);
      checks++;
      if ({o_pred_ghr, o_pred_idx} !== {8'h07, 8'h17}) begin
         errors++; $display("FAIL spec_ghr: got %h expected %h", {o_pred_ghr, o_pred_idx}, {8'h07, 8'h17});
      end
   endtask

   task automatic test_mispred();
      spec(1); spec(0);
      // mispredict repair with a concurrent spec shift that must be discarded
      step(0, 0, 0, 1, 1, 1, 8'h33, 0, 1, 8'h05);
      query(32'h100);
      checks++;
      if ({o_pred_ghr, o_pred_idx} !== {8'h0A, 8'h1A}) begin
         errors++; $display("FAIL mispred_ghr: got %h expected %h", {o_pred_ghr, o_pred_idx}, {8'h0A, 8'h1A});
      end
   endtask

   task automatic test_flush();
      apply_reset();
      upd(8'h40, 1); upd(8'h40, 1);
      for (int i = 0; i < 5; i++) spec(1);
      step(1, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (o_pred_vld !== 1'b0) begin
         errors++; $display("FAIL flush_drop: got %b expected 0", o_pred_vld);
      end
      query(32'h100);
      checks++;
      if (o_pred_ghr !== 8'h03) begin
         errors++; $display("FAIL flush_ghr: got %h expected 03", o_pred_ghr);
      end
      spec(0); spec(1); spec(1);
      step(1, 1, 32'h100, 1, 0, 1, 8'h41, 1, 1, 8'h55);
      checks++;
      if (o_pred_vld !== 1'b0) begin
         errors++; $display("FAIL flush_mis_drop: got %b expected 0", o_pred_vld);
      end
      query(32'h100);
      checks++;
      if (o_pred_ghr !== 8'h07) begin
         errors++; $display("FAIL flush_mis_ghr: got %h expected 07", o_pred_ghr);
      end
   endtask

   task automatic test_bypass();
      apply_reset();
      step(0, 1, 32'h200, 0, 0, 1, 8'h20, 1, 0, 0);
      checks++;
      if ({o_pred_idx, o_pred_ctr, o_pred_taken} !== {8'h20, 2'd2, 1'b1}) begin
         errors++; $display("FAIL bypass_inc: got %h expected %h", {o_pred_idx, o_pred_ctr, o_pred_taken}, {8'h20, 2'd2, 1'b1});
      end
      step(0, 1, 32'h200, 0, 0, 1, 8'h20, 0, 0, 0);
      checks++;
      if ({o_pred_ctr, o_pred_taken} !== {2'd1, 1'b0}) begin
         errors++; $display("FAIL bypass_dec: got %h expected %h", {o_pred_ctr, o_pred_taken}, {2'd1, 1'b0});
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         logic [31:0] pc;
         logic [7:0]  ui, hidx;
         pc   = $urandom;
         pc[11:8] = 4'($urandom_range(0, 1));  // concentrate traffic on few entries
         hidx = pc[11:4] ^ 8'(m_sghr);
         ui   = ($urandom_range(0, 2) == 0) ? hidx : 8'($urandom_range(0, 31));
         step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), pc,
              1'($urandom), 1'($urandom), 1'($urandom), ui, 1'($urandom),
              ($urandom_range(0, 7) == 0), 8'($urandom));
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL random_cycle_%0d: got %h expected %h", n, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_mid_reset();
      for (int n = 0; n < 20; n++) step(0, 0, 0, 1, 1, 1, 8'($urandom), 1, 0, 0);
      apply_reset();
      checks++;
      if (obs_vec() !== 20'h0) begin
         errors++; $display("FAIL midreset_outputs: got %h expected %h", obs_vec(), 20'h0);
      end
      for (int n = 0; n < 8; n++) begin
         logic [31:0] pc;
         pc = $urandom;
         query(pc);
         checks++;
         if ({o_pred_idx, o_pred_ctr, o_pred_ghr} !== {pc[11:4], 2'd1, 8'h00}) begin
            errors++; $display("FAIL midreset_query_%0d: got %h expected %h", n, {o_pred_idx, o_pred_ctr, o_pred_ghr}, {pc[11:4], 2'd1, 8'h00});
         end
      end
   endtask

   initial begin
      model_init();
      test_reset();
      test_saturation();
      test_spec_history();
      test_mispred();
      test_flush();
      test_bypass();
      test_random();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
